// File: rtl/imm_pack_encoder_if.sv
// rtl/imm_pack_encoder_if.sv - request/result handshake bundle for imm_pack_encoder
interface imm_pack_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_imm;
  logic [24:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_inst;
  logic        out_err;
  logic [2:0]  out_ctrl;

  modport master (
    output in_valid, in_ctrl, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_ctrl
  );

  modport slave (
    input  in_valid, in_ctrl, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_ctrl
  );
endinterface

// File: rtl/imm_pack_encoder.sv
// rtl/imm_pack_encoder.sv - RV32I immediate range-check and scatter into inst[31:7], 2-stage pipe
module imm_pack_encoder #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_pack_encoder_if.slave bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_IU = 3'd1;
  localparam logic [2:0] FMT_SH = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;
  localparam logic [2:0] FMT_U  = 3'd5;
  localparam logic [2:0] FMT_J  = 3'd6;

  logic        s1_v_q, s1_legal_q;
  logic [2:0]  s1_ctrl_q;
  logic [20:0] s1_imm_q;
  logic [24:0] s1_base_q;
  logic        s2_v_q, s2_err_q;
  logic [2:0]  s2_ctrl_q;
  logic [24:0] s2_inst_q;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;

  logic        s1_adv, s2_adv, out_hs;
  logic        legal_d;
  logic [24:0] mask, field, s2_inst_d;
  logic [31:0] imm;

  assign s2_adv = ~s2_v_q | bus.out_ready;
  assign s1_adv = ~s1_v_q | s2_adv;
  assign out_hs = s2_v_q & bus.out_ready;
  assign imm    = bus.in_imm;

  // Legality: the bits above the encodable range must be a pure sign extension.
  always_comb begin
    legal_d = 1'b0;
    case (bus.in_ctrl)
      FMT_I, FMT_S: legal_d = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_IU:       legal_d = ~(|imm[31:12]);
      FMT_SH:       legal_d = (&imm[31:4]) | ~(|imm[31:4]);
      FMT_B:        legal_d = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
      FMT_U:        legal_d = (&imm[31:19]) | ~(|imm[31:19]);
      FMT_J:        legal_d = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
      default:      legal_d = 1'b0;
    endcase
  end

  always_comb begin
    mask  = '0;
    field = '0;
    case (s1_ctrl_q)
      FMT_I, FMT_IU: begin
        mask         = 25'h1FFE000;
        field[24:13] = s1_imm_q[11:0];
      end
      FMT_SH: begin
        mask         = 25'h003E000;
        field[17:13] = s1_imm_q[4:0];
      end
      FMT_S: begin
        mask         = 25'h1FC001F;
        field[24:18] = s1_imm_q[11:5];
        field[4:0]   = s1_imm_q[4:0];
      end
      FMT_B: begin
        mask         = 25'h1FC001F;
        field[24]    = s1_imm_q[12];
        field[23:18] = s1_imm_q[10:5];
        field[4:1]   = s1_imm_q[4:1];
        field[0]     = s1_imm_q[11];
      end
      FMT_U: begin
        mask         = 25'h1FFFFE0;
        field[24:5]  = s1_imm_q[19:0];
      end
      FMT_J: begin
        mask         = 25'h1FFFFE0;
        field[24]    = s1_imm_q[20];
        field[23:14] = s1_imm_q[10:1];
        field[13]    = s1_imm_q[11];
        field[12:5]  = s1_imm_q[19:12];
      end
      default: begin
        mask  = '0;
        field = '0;
      end
    endcase
    s2_inst_d = (s1_base_q & ~mask) | field;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_legal_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
    end else if (s1_adv) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_legal_q <= legal_d;
        s1_ctrl_q  <= bus.in_ctrl;
        s1_imm_q   <= bus.in_imm[20:0];
        s1_base_q  <= bus.in_base;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_ctrl_q <= '0;
      s2_inst_q <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_err_q  <= ~s1_legal_q;
        s2_ctrl_q <= s1_ctrl_q;
        s2_inst_q <= s2_inst_d;
      end
    end
  end

  // Clear wins over a same-cycle delivery; counts stick at all-ones.
  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (cnt_clr) begin
      cnt_ok_d  = '0;
      cnt_err_d = '0;
    end else if (out_hs) begin
      if (s2_err_q) begin
        if (~&cnt_err_q) cnt_err_d = cnt_err_q + CNT_W'(1);
      end else begin
        if (~&cnt_ok_q) cnt_ok_d = cnt_ok_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v_q;
  assign bus.out_inst  = s2_inst_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_ctrl  = s2_ctrl_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_imm_pack_encoder.sv
// tb/tb_imm_pack_encoder.sv - directed self-checking bench for imm_pack_encoder
module tb_imm_pack_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr_a, clr_b;
  logic [15:0] ok_a, err_a;
  logic [1:0]  ok_b, err_b;

  imm_pack_encoder_if ifa ();
  imm_pack_encoder_if ifb ();

  imm_pack_encoder #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .cnt_clr(clr_a), .cnt_ok(ok_a), .cnt_err(err_a)
  );

  imm_pack_encoder #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .cnt_clr(clr_b), .cnt_ok(ok_b), .cnt_err(err_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [2:0] ctrl, input logic [31:0] imm,
                       input logic [24:0] base, input logic [24:0] e_inst, input logic e_err);
    ifa.in_valid  = 1'b1;
    ifa.in_ctrl   = ctrl;
    ifa.in_imm    = imm;
    ifa.in_base   = base;
    ifa.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(ifa.in_ready), 32'd1);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(ifa.out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(ifa.out_valid), 32'd1);
    chk({tag, ".inst"}, 32'(ifa.out_inst), 32'(e_inst));
    chk({tag, ".err"}, 32'(ifa.out_err), 32'(e_err));
    chk({tag, ".ctrl"}, 32'(ifa.out_ctrl), 32'(ctrl));
    @(posedge clk); #1;
  endtask

  logic [24:0] exp_q [8];
  logic [31:0] st_imm;
  int sent, got;
  logic in_hs, out_hs;

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_ctrl = '0; ifa.in_imm = '0; ifa.in_base = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_ctrl = '0; ifb.in_imm = '0; ifb.in_base = '0; ifb.out_ready = 1'b1;
    #1;
    chk("rst.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst.in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst.out_inst", 32'(ifa.out_inst), 32'd0);
    chk("rst.cnt_ok", 32'(ok_a), 32'd0);
    chk("rst.cnt_err", 32'(err_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_a("I.neg",    3'd0, 32'hFFFFF800, 25'h0, 25'h1000000, 1'b0);
    run_a("I.ovf",    3'd0, 32'h00000800, 25'h0, 25'h1000000, 1'b1);
    run_a("IU.max",   3'd1, 32'h00000FFF, 25'h0, 25'h1FFE000, 1'b0);
    run_a("IU.neg",   3'd1, 32'hFFFFFFFF, 25'h0, 25'h1FFE000, 1'b1);
    run_a("SH.neg",   3'd2, 32'hFFFFFFF0, 25'h0, 25'h0020000, 1'b0);
    run_a("SH.ovf",   3'd2, 32'h00000010, 25'h0, 25'h0020000, 1'b1);
    run_a("S.ones",   3'd3, 32'h000007FF, 25'h1FFFFFF, 25'h0FFFFFF, 1'b0);
    run_a("S.base",   3'd3, 32'h000007FF, 25'h0000FE0, 25'h0FC0FFF, 1'b0);
    run_a("B.max",    3'd4, 32'h00000FFE, 25'h0, 25'h0FC001F, 1'b0);
    run_a("B.odd",    3'd4, 32'h00001001, 25'h0, 25'h1000000, 1'b1);
    run_a("U.neg",    3'd5, 32'hFFF80000, 25'h0, 25'h1000000, 1'b0);
    run_a("J.max",    3'd6, 32'h000FFFFE, 25'h000001F, 25'h0FFFFFF, 1'b0);
    run_a("J.ovf",    3'd6, 32'h00100000, 25'h0, 25'h1000000, 1'b1);
    run_a("C7",       3'd7, 32'h00000000, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1);

    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    chk("clr.cnt_ok", 32'(ok_a), 32'd0);
    chk("clr.cnt_err", 32'(err_a), 32'd0);

    // eight U-format words streamed against a 1010 out_ready pattern
    for (int i = 0; i < 8; i++) begin
      st_imm = 32'h00011111 * i;
      exp_q[i] = {st_imm[19:0], 5'h1F};
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      ifa.out_ready = (cyc % 2 == 0);
      ifa.in_valid  = (sent < 8);
      ifa.in_ctrl   = 3'd5;
      ifa.in_imm    = 32'h00011111 * sent;
      ifa.in_base   = 25'h000001F;
      #1;
      in_hs  = ifa.in_valid && ifa.in_ready;
      out_hs = ifa.out_valid && ifa.out_ready;
      if (out_hs) begin
        chk($sformatf("stream.inst%0d", got), 32'(ifa.out_inst), 32'(exp_q[got]));
        chk($sformatf("stream.err%0d", got), 32'(ifa.out_err), 32'd0);
        got++;
      end
      @(posedge clk); #1;
      if (in_hs) sent++;
    end
    ifa.in_valid = 1'b0;
    chk("stream.sent", 32'(sent), 32'd8);
    chk("stream.got", 32'(got), 32'd8);
    chk("stream.cnt_ok", 32'(ok_a), 32'd8);
    chk("stream.cnt_err", 32'(err_a), 32'd0);

    // fill the pipe with out_ready low, confirm hold, then reset mid-stream
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_ctrl   = 3'd0;
    ifa.in_imm    = 32'h00000005;
    ifa.in_base   = 25'h0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold.valid", 32'(ifa.out_valid), 32'd1);
    chk("hold.in_ready", 32'(ifa.in_ready), 32'd0);
    chk("hold.inst0", 32'(ifa.out_inst), 32'h000A000);
    @(posedge clk); #1;
    chk("hold.inst1", 32'(ifa.out_inst), 32'h000A000);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(ifa.out_valid), 32'd0);
    chk("midrst.cnt_ok", 32'(ok_a), 32'd0);
    ifa.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst.valid_next", 32'(ifa.out_valid), 32'd0);
    chk("midrst.cnt_ok_next", 32'(ok_a), 32'd0);
    chk("midrst.in_ready", 32'(ifa.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CNT_W=2 instance: five bad requests saturate at 3
    ifb.in_ctrl = 3'd7;
    ifb.in_base = 25'h0000123;
    ifb.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat.cnt_err", 32'(err_b), 32'd3);
    chk("sat.cnt_ok", 32'(ok_b), 32'd0);

    ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clrhs.valid", 32'(ifb.out_valid), 32'd1);
    chk("clrhs.err", 32'(ifb.out_err), 32'd1);
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    chk("clrhs.cnt_err", 32'(err_b), 32'd0);
    chk("clrhs.drained", 32'(ifb.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
